// File: rtl/contador_pkg.sv
//------------------------------------------------------------------------------
// contador_pkg
// Shared definitions for the contador_param per-channel transfer counter:
//   - rd_state_t   : read-port FSM encoding (RD_IDLE, RD_RESP)
//   - C_ESTADO_REPORT_DEF : default system-FSM encoding of the report state
//   - idx_width()  : width of a channel index, never less than 1 bit
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package contador_pkg;

  typedef enum logic [0:0] {
    RD_IDLE = 1'b0,
    RD_RESP = 1'b1
  } rd_state_t;

  localparam int C_ESTADO_REPORT_DEF = 4;

  // A single channel still needs a 1-bit index so the read port exists.
  function automatic int idx_width(input int n);
    if (n <= 1) return 1;
    return $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/contador_param_if.sv
//------------------------------------------------------------------------------
// contador_param_if
// Indexed read port of contador_param.
//   req   : read request (master -> slave)
//   idx   : channel selected by req (master -> slave)
//   total : read data, valid while valid=1 (slave -> master)
//   valid : one-cycle response pulse (slave -> master)
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface contador_param_if #(
  parameter int IDX_W = 2,
  parameter int CNT_W = 5
);

  logic             req;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] total;
  logic             valid;

  modport master (output req, output idx, input total, input valid);
  modport slave  (input req, input idx, output total, output valid);

endinterface

`default_nettype wire

// File: rtl/contador_canal.sv
//------------------------------------------------------------------------------
// contador_canal
// One live channel counter with its sticky overflow flag.
//   clk, rst : clock, synchronous active-high reset
//   i_clr    : synchronous clear of counter and overflow flag
//   i_push   : one word moved on this channel this cycle
//   o_cnt    : registered live count
//   o_ovf    : sticky overflow flag
// Build option: CONTADOR_SAT_EN defined -> counter saturates at all-ones;
//               undefined -> counter wraps modulo 2^CNT_W.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module contador_canal #(
  parameter int CNT_W = 5
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             i_clr,
  input  wire logic             i_push,
  output logic      [CNT_W-1:0] o_cnt,
  output logic                  o_ovf
);

  localparam logic [CNT_W-1:0] C_MAX = '1;

  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;
  logic             w_at_max;

  assign w_at_max = (r_cnt == C_MAX);

  // rst/clr win over a simultaneous push.
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (i_push) begin
      if (w_at_max) begin
        r_ovf <= 1'b1;
`ifdef CONTADOR_SAT_EN
        r_cnt <= C_MAX;
`else
        r_cnt <= '0;
`endif
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_cnt = r_cnt;
  assign o_ovf = r_ovf;

endmodule

`default_nettype wire

// File: rtl/contador_param.sv
//------------------------------------------------------------------------------
// contador_param
// Parametrised per-channel transfer counter. Counts push strobes per channel,
// freezes a snapshot on entry to the system report state and serves it on a
// flat bus and through an indexed request/valid read port.
//   clk, rst    : clock, synchronous active-high reset
//   Estado      : current system FSM state
//   push        : per-channel transfer strobes
//   clr         : synchronous clear of live counters and overflow flags
//   rd          : indexed read port (req/idx in, total/valid out)
//   totals_flat : snapshot bus, channel i at [i*CNT_W +: CNT_W], 0 outside report
//   ovf         : sticky per-channel overflow flags
// Build option: CONTADOR_SAT_EN selects saturating counters (default: wrap).
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module contador_param
  import contador_pkg::*;
#(
  parameter int N_CH          = 4,
  parameter int CNT_W         = 5,
  parameter int ESTADO_W      = 4,
  parameter int ESTADO_REPORT = C_ESTADO_REPORT_DEF
) (
  input  wire logic                  clk,
  input  wire logic                  rst,
  input  wire logic [ESTADO_W-1:0]   Estado,
  input  wire logic [N_CH-1:0]       push,
  input  wire logic                  clr,
  contador_param_if.slave            rd,
  output logic [N_CH*CNT_W-1:0]      totals_flat,
  output logic [N_CH-1:0]            ovf
);

  localparam int                  IDX_W    = idx_width(N_CH);
  localparam int                  N_SLOT   = 1 << IDX_W;
  localparam logic [ESTADO_W-1:0] C_REPORT = ESTADO_REPORT[ESTADO_W-1:0];

  // ---------------------------------------------------------------- counters
  logic [N_CH*CNT_W-1:0] w_cnt_flat;
  logic [N_CH-1:0]       w_ovf;

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_canal
      contador_canal #(
        .CNT_W (CNT_W)
      ) u_canal (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (clr),
        .i_push (push[gi]),
        .o_cnt  (w_cnt_flat[gi*CNT_W +: CNT_W]),
        .o_ovf  (w_ovf[gi])
      );
    end
  endgenerate

  assign ovf = w_ovf;

  // --------------------------------------------------- report entry/snapshot
  logic                  r_rep_q;
  logic [N_CH*CNT_W-1:0] r_snap;
  logic [N_CH*CNT_W-1:0] r_flat;
  logic                  w_is_report;
  logic                  w_entry;

  assign w_is_report = (Estado == C_REPORT);
  assign w_entry     = w_is_report && !r_rep_q;

  // The snapshot takes the counters' registered values, so a push landing on
  // the entry cycle goes into the live counter but not into this report.
  // The flat view follows r_rep_q one cycle late, so it is published one
  // edge after entry and drops one edge after rep_q falls. clr never touches
  // the snapshot.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rep_q <= 1'b0;
      r_snap  <= '0;
      r_flat  <= '0;
    end else begin
      r_rep_q <= w_is_report;
      if (w_entry) begin
        r_snap <= w_cnt_flat;
      end
      r_flat <= r_rep_q ? r_snap : '0;
    end
  end

  assign totals_flat = r_flat;

  // --------------------------------------------------------- indexed read port
  // Snapshot padded to a power-of-two table: indices at or beyond N_CH land
  // on zero slots, which gives total=0 for out-of-range requests.
  logic [CNT_W-1:0] w_slot [N_SLOT];

  generate
    for (genvar gs = 0; gs < N_SLOT; gs++) begin : g_slot
      if (gs < N_CH) begin : g_live
        assign w_slot[gs] = r_snap[gs*CNT_W +: CNT_W];
      end else begin : g_pad
        assign w_slot[gs] = '0;
      end
    end
  endgenerate

  rd_state_t        r_state;
  rd_state_t        w_state_nxt;
  logic [IDX_W-1:0] r_idx;
  logic             w_accept;
  logic             w_valid;
  logic [CNT_W-1:0] w_total;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RD_IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_idx <= rd.idx;
      end
    end
  end

  // Requests are only seen in RD_IDLE, so a req during the response cycle is
  // dropped rather than queued.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_valid     = 1'b0;
    w_total     = '0;
    case (r_state)
      RD_IDLE: begin
        if (rd.req && r_rep_q) begin
          w_accept    = 1'b1;
          w_state_nxt = RD_RESP;
        end
      end
      RD_RESP: begin
        w_valid     = 1'b1;
        w_total     = w_slot[r_idx];
        w_state_nxt = RD_IDLE;
      end
      default: begin
        w_state_nxt = RD_IDLE;
      end
    endcase
  end

  assign rd.valid = w_valid;
  assign rd.total = w_total;

endmodule

`default_nettype wire

// File: tb/tb_contador_param.sv
//------------------------------------------------------------------------------
// tb_contador_param
// Directed bench for contador_param (N_CH=4, CNT_W=5, report state 4) plus a
// second N_CH=3 instance whose 2-bit index can address a missing channel.
// Honours CONTADOR_SAT_EN for the overflow expectation.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_contador_param;

  localparam int N_CH  = 4;
  localparam int CNT_W = 5;
  localparam int EST_W = 4;

`ifdef CONTADOR_SAT_EN
  localparam logic [4:0] C_OVF_CNT = 5'd31;
`else
  localparam logic [4:0] C_OVF_CNT = 5'd1;
`endif

  logic             clk;
  logic             rst;
  logic [EST_W-1:0] estado;
  logic [N_CH-1:0]  push;
  logic             clr;
  logic [19:0]      totals_flat;
  logic [3:0]       ovf;
  logic [14:0]      totals_flat3;
  logic [2:0]       ovf3;

  int n_cmp;
  int n_fail;

  contador_param_if #(.IDX_W(2), .CNT_W(CNT_W)) rd_if ();
  contador_param_if #(.IDX_W(2), .CNT_W(CNT_W)) rd3_if ();

  contador_param #(
    .N_CH(N_CH), .CNT_W(CNT_W), .ESTADO_W(EST_W), .ESTADO_REPORT(4)
  ) u_dut (
    .clk(clk), .rst(rst), .Estado(estado), .push(push), .clr(clr),
    .rd(rd_if.slave), .totals_flat(totals_flat), .ovf(ovf)
  );

  contador_param #(
    .N_CH(3), .CNT_W(CNT_W), .ESTADO_W(EST_W), .ESTADO_REPORT(4)
  ) u_dut3 (
    .clk(clk), .rst(rst), .Estado(estado), .push(push[2:0]), .clr(clr),
    .rd(rd3_if.slave), .totals_flat(totals_flat3), .ovf(ovf3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [19:0] pack4(input logic [4:0] c3, input logic [4:0] c2,
                                        input logic [4:0] c1, input logic [4:0] c0);
    return {c3, c2, c1, c0};
  endfunction

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst = 1'b1; estado = '0; push = '1; clr = 1'b0;
    rd_if.req = 1'b0;  rd_if.idx = '0;
    rd3_if.req = 1'b0; rd3_if.idx = '0;

    // Reset held 3 cycles with all pushes active
    repeat (3) tick();
    check("rst_flat",  totals_flat, 20'd0);
    check("rst_ovf",   ovf, 4'd0);
    check("rst_valid", rd_if.valid, 1'b0);
    check("rst_total", rd_if.total, 5'd0);
    rst = 1'b0; push = '0;
    tick();
    check("post_rst_ovf",  ovf, 4'd0);
    check("post_rst_flat", totals_flat, 20'd0);

    // ch0 x3, ch2 x7
    push = 4'b0001; repeat (3) tick();
    push = 4'b0100; repeat (7) tick();
    // Entry cycle with a ch1 push that must not reach this snapshot
    push = 4'b0010; estado = 4'd4;
    tick();
    push = '0;
    check("flat_at_entry", totals_flat, 20'd0);
    tick();
    check("flat_publish", totals_flat, pack4(5'd0, 5'd7, 5'd0, 5'd3));

    // Read idx=2, keep req high in the response cycle (must be dropped);
    // the 3-channel instance reads missing channel 3
    rd_if.req = 1'b1;  rd_if.idx = 2'd2;
    rd3_if.req = 1'b1; rd3_if.idx = 2'd3;
    tick();
    rd_if.idx = 2'd0;
    check("rd2_valid", rd_if.valid, 1'b1);
    check("rd2_total", rd_if.total, 5'd7);
    check("rd3_oor_valid", rd3_if.valid, 1'b1);
    check("rd3_oor_total", rd3_if.total, 5'd0);
    tick();
    rd_if.req = 1'b0; rd3_if.req = 1'b0;
    check("b2b_dropped", rd_if.valid, 1'b0);
    tick();
    check("b2b_no_late", rd_if.valid, 1'b0);

    rd_if.req = 1'b1; rd_if.idx = 2'd0;
    tick();
    rd_if.req = 1'b0;
    check("rd0_total", rd_if.total, 5'd3);
    tick();
    check("rd0_pulse_end", rd_if.valid, 1'b0);

    // Leave report: view drops one cycle after rep_q falls
    estado = 4'd0;
    tick();
    check("leave_hold", totals_flat, pack4(5'd0, 5'd7, 5'd0, 5'd3));
    tick();
    check("leave_zero", totals_flat, 20'd0);

    // Request outside report is dropped
    rd_if.req = 1'b1; rd_if.idx = 2'd2;
    tick();
    rd_if.req = 1'b0;
    check("req_no_report", rd_if.valid, 1'b0);

    // Re-entry includes the earlier entry-cycle push on ch1
    estado = 4'd4;
    tick(); tick();
    check("reentry_flat", totals_flat, pack4(5'd0, 5'd7, 5'd1, 5'd3));
    estado = 4'd0;
    tick(); tick();

    // Overflow on ch3 after a clear
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_ovf", ovf, 4'd0);
    push = 4'b1000;
    for (int i = 0; i < 33; i++) tick();
    push = '0;
    check("ovf_set", ovf, 4'b1000);
    check("ovf3_none", ovf3, 3'd0);
    estado = 4'd4;
    tick(); tick();
    check("ovf_flat", totals_flat, pack4(C_OVF_CNT, 5'd0, 5'd0, 5'd0));
    rd_if.req = 1'b1; rd_if.idx = 2'd3;
    tick();
    rd_if.req = 1'b0;
    check("ovf_rd_total", rd_if.total, C_OVF_CNT);
    tick();

    // clr with simultaneous pushes: counters and ovf cleared, snapshot kept
    clr = 1'b1; push = 4'b1111;
    tick();
    clr = 1'b0; push = '0;
    check("clr_push_ovf", ovf, 4'd0);
    check("clr_keeps_snap", totals_flat, pack4(C_OVF_CNT, 5'd0, 5'd0, 5'd0));
    estado = 4'd0;
    tick();
    estado = 4'd4;
    tick(); tick();
    check("clr_push_cnt", totals_flat, 20'd0);

    // rst in the response cycle: no completion, valid low after the edge
    rd_if.req = 1'b1; rd_if.idx = 2'd2;
    tick();
    rd_if.req = 1'b0;
    check("resp_before_rst", rd_if.valid, 1'b1);
    rst = 1'b1;
    tick();
    check("rst_mid_valid", rd_if.valid, 1'b0);
    check("rst_mid_flat", totals_flat, 20'd0);
    rst = 1'b0; estado = 4'd0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
